// File: rtl/wb_trace_buffer_pkg.sv
// wb_trace_buffer_pkg: trace record layout and default sizing shared by the trace buffer
package wb_trace_buffer_pkg;
  localparam int DEPTH_DEF  = 8;
  localparam int CNT_W_DEF  = 4;
  localparam int DROP_W_DEF = 16;
  // Field order fixes the bit offsets: pc[101:70] inst[69:38] we[37] wreg[36:32] wdata[31:0]
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } trc_rec_t;
  localparam int TRC_REC_W = $bits(trc_rec_t);
  // Writes to r0 never change architectural state, so they are traced with we=0
  function automatic trc_rec_t pack_rec(logic [31:0] pc, logic [31:0] inst, logic ena,
                                        logic [4:0] wreg, logic [31:0] wdata);
    return '{pc: pc, inst: inst, we: ena & (wreg != 5'd0), wreg: wreg, wdata: wdata};
  endfunction
endpackage

// File: rtl/wb_trace_buffer_if.sv
// wb_trace_buffer_if: retiring-instruction input and trace-sink handshake bundle
interface wb_trace_buffer_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic        wb_ena;
  logic [4:0]  wb_reg;
  logic [31:0] wb_wdata;
  logic        trc_ready;
  logic        trc_valid;
  logic [31:0] trc_pc;
  logic [31:0] trc_inst;
  logic        trc_we;
  logic [4:0]  trc_wreg;
  logic [31:0] trc_wdata;
  modport master (
    output wb_valid, wb_pc, wb_inst, wb_ena, wb_reg, wb_wdata, trc_ready,
    input  trc_valid, trc_pc, trc_inst, trc_we, trc_wreg, trc_wdata
  );
  modport slave (
    input  wb_valid, wb_pc, wb_inst, wb_ena, wb_reg, wb_wdata, trc_ready,
    output trc_valid, trc_pc, trc_inst, trc_we, trc_wreg, trc_wdata
  );
endinterface

// File: rtl/wb_trace_buffer_fifo.sv
// wb_trace_buffer_fifo: DEPTH x W synchronous show-ahead FIFO with occupancy count
module wb_trace_buffer_fifo
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int W     = TRC_REC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  // Pointers wrap naturally at DEPTH; fullness is judged by the caller from count only
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end
  // Control state; reset discards everything queued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // Storage is left unreset; its contents are masked while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures retiring WB instructions and drains them to the trace port
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_trace_buffer_if.slave  bus,
  input  logic              clr_ovf,
  output logic              stall_req,
  output logic [CNT_W-1:0]  count,
  output logic              ovf_sticky,
  output logic [DROP_W-1:0] drop_cnt
);
  logic              push, pop, full, empty, ovf;
  trc_rec_t          rec, head, head_vis;
  logic              ovf_sticky_q, ovf_sticky_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  wb_trace_buffer_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W), .W(TRC_REC_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .din(rec), .dout(head), .count(count)
  );
  // Handshake, overflow accounting and the zero-masked head view
  always_comb begin
    empty        = count == '0;
    full         = count == CNT_W'(DEPTH);
    pop          = !empty & bus.trc_ready;
    push         = bus.wb_valid & (!full | pop);
    ovf          = bus.wb_valid & full & !pop;
    rec          = pack_rec(bus.wb_pc, bus.wb_inst, bus.wb_ena, bus.wb_reg, bus.wb_wdata);
    head_vis     = empty ? '0 : head;
    ovf_sticky_d = clr_ovf ? ovf : (ovf_sticky_q | ovf);
    drop_cnt_d   = clr_ovf ? DROP_W'(ovf) : drop_cnt_q + DROP_W'(ovf & ~&drop_cnt_q);
  end
  // Overflow status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end
  // The spare slot absorbs the instruction already in WB when the stall rises
  assign stall_req     = count >= CNT_W'(DEPTH - 1);
  assign ovf_sticky    = ovf_sticky_q;
  assign drop_cnt      = drop_cnt_q;
  assign bus.trc_valid = !empty;
  assign bus.trc_pc    = head_vis.pc;
  assign bus.trc_inst  = head_vis.inst;
  assign bus.trc_we    = head_vis.we;
  assign bus.trc_wreg  = head_vis.wreg;
  assign bus.trc_wdata = head_vis.wdata;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed and random checks of wb_trace_buffer against a queue model
module tb_wb_trace_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        stall_req, ovf_sticky;
  logic [3:0]  count;
  logic [15:0] drop_cnt;
  int          total = 0;
  int          bad = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } rec_t;
  rec_t q[$];
  bit   m_ovf = 1'b0;
  int   m_drop = 0;
  wb_trace_buffer_if bus ();
  wb_trace_buffer dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr_ovf(clr_ovf),
    .stall_req(stall_req), .count(count), .ovf_sticky(ovf_sticky), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    rec_t h;
    h = '{pc: 0, inst: 0, we: 0, wreg: 0, wdata: 0};
    if (q.size() > 0) h = q[0];
    chk("valid", bus.trc_valid, q.size() > 0);
    chk("pc", bus.trc_pc, h.pc);
    chk("inst", bus.trc_inst, h.inst);
    chk("we", bus.trc_we, h.we);
    chk("wreg", bus.trc_wreg, h.wreg);
    chk("wdata", bus.trc_wdata, h.wdata);
    chk("count", count, q.size());
    chk("stall", stall_req, q.size() >= 7);
    chk("ovf", ovf_sticky, m_ovf);
    chk("drop", drop_cnt, m_drop);
  endtask
  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst, input bit ena,
                       input logic [4:0] r, input logic [31:0] d, input bit rdy, input bit clr);
    bus.wb_valid = v; bus.wb_pc = pc; bus.wb_inst = inst; bus.wb_ena = ena;
    bus.wb_reg = r; bus.wb_wdata = d; bus.trc_ready = rdy; clr_ovf = clr;
  endtask
  task automatic drive_rand(input bit v, input bit rdy, input bit clr);
    drive(v, $urandom, $urandom, 1'($urandom), 5'($urandom_range(0, 31)), $urandom, rdy, clr);
  endtask
  task automatic tick();
    bit pop, push, of;
    pop  = q.size() > 0 && bus.trc_ready;
    push = bus.wb_valid && (q.size() < 8 || pop);
    of   = bus.wb_valid && q.size() == 8 && !pop;
    if (pop) void'(q.pop_front());
    if (push) q.push_back('{pc: bus.wb_pc, inst: bus.wb_inst,
                            we: bus.wb_ena && bus.wb_reg != 0, wreg: bus.wb_reg, wdata: bus.wb_wdata});
    if (clr_ovf) begin
      m_ovf = of;
      m_drop = of ? 1 : 0;
    end else if (of) begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask
  initial begin
    int pushed, budget;
    bit v;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_all();
    drive(1, 32'h1c000000, 32'h02801004, 1, 5'd4, 32'h10, 1, 0);
    tick();
    chk("t2_we", bus.trc_we, 1);
    chk("t2_wreg", bus.trc_wreg, 4);
    chk("t2_pc", bus.trc_pc, 32'h1c000000);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    chk("t2_count", count, 0);
    drive(1, 32'h1c000004, 32'h12345678, 1, 5'd0, 32'hDEAD, 1, 0);
    tick();
    chk("t3_we", bus.trc_we, 0);
    chk("t3_wreg", bus.trc_wreg, 0);
    chk("t3_wdata", bus.trc_wdata, 32'hDEAD);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive_rand(1, 0, 0);
      tick();
    end
    chk("t4_stall", stall_req, 1);
    chk("t4_count7", count, 7);
    drive_rand(1, 0, 0);
    tick();
    chk("t4_count8", count, 8);
    drive_rand(1, 0, 0);
    tick();
    chk("t4_ovf", ovf_sticky, 1);
    chk("t4_drop", drop_cnt, 1);
    chk("t4_count_full", count, 8);
    drive_rand(1, 1, 0);
    tick();
    chk("t5_count", count, 8);
    chk("t5_drop", drop_cnt, 1);
    drive_rand(1, 0, 0);
    tick();
    chk("ovf_drop2", drop_cnt, 2);
    drive_rand(1, 0, 1);
    tick();
    chk("clr_ovf_same_ovf", ovf_sticky, 1);
    chk("clr_drop_same_ovf", drop_cnt, 1);
    drive_rand(0, 0, 1);
    tick();
    chk("clr_ovf", ovf_sticky, 0);
    chk("clr_drop", drop_cnt, 0);
    for (int i = 0; i < 9; i++) begin
      drive_rand(0, 1, 0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive_rand(1, 0, 0);
      tick();
    end
    chk("t1_count5", count, 5);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_count", count, 0);
    chk("t1_rst_valid", bus.trc_valid, 0);
    chk("t1_rst_pc", bus.trc_pc, 0);
    q.delete();
    m_ovf = 1'b0;
    m_drop = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand(0, 1, 0);
      tick();
    end
    pushed = 0;
    budget = 0;
    while (pushed < 20 && budget < 500) begin
      v = !stall_req && ($urandom_range(0, 3) != 0);
      drive(v, 32'h1000 + 32'(pushed) * 4, $urandom, 1'($urandom), 5'($urandom_range(0, 31)),
            $urandom, 1'($urandom), 0);
      tick();
      if (v) pushed++;
      budget++;
    end
    budget = 0;
    while (q.size() > 0 && budget < 50) begin
      drive_rand(0, 1, 0);
      tick();
      budget++;
    end
    chk("t6_pushed", pushed, 20);
    chk("t6_drained", count, 0);
    chk("t6_drop", drop_cnt, 0);
    for (int i = 0; i < 300; i++) begin
      drive_rand(1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
